// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types and constants for the vending transaction sequencer
// Contents: state encoding, switch modes, money/code widths, price formula
// constants and the coin value lookup.
package vend_pkg;

  localparam int MONEY_W = 13;
  localparam int CODE_W  = 4;

  localparam logic [MONEY_W-1:0] MONEY_MAX    = '1;
  localparam logic [MONEY_W-1:0] PRICE_BASE   = 13'd50;
  localparam logic [MONEY_W-1:0] PRICE_STEP   = 13'd25;
  localparam logic [CODE_W-1:0]  INVALID_CODE = 4'd15;

  localparam logic [MONEY_W-1:0] COIN_IDX0 = 13'd5;
  localparam logic [MONEY_W-1:0] COIN_IDX1 = 13'd10;
  localparam logic [MONEY_W-1:0] COIN_IDX2 = 13'd25;
  localparam logic [MONEY_W-1:0] COIN_IDX3 = 13'd100;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CODE  = 3'd1,
    ST_CHECK = 3'd2,
    ST_PAY   = 3'd3,
    ST_VEND  = 3'd4,
    ST_ABORT = 3'd5
  } state_t;

  localparam logic [1:0] SW_CANCEL = 2'b00;
  localparam logic [1:0] SW_CODE   = 2'b01;
  localparam logic [1:0] SW_PAY    = 2'b11;

  function automatic logic [MONEY_W-1:0] coin_value(input logic [1:0] idx);
    case (idx)
      2'd0:    coin_value = COIN_IDX0;
      2'd1:    coin_value = COIN_IDX1;
      2'd2:    coin_value = COIN_IDX2;
      default: coin_value = COIN_IDX3;
    endcase
  endfunction

endpackage

// File: rtl/vend_price_rom.sv
// rtl/vend_price_rom.sv - combinational item code to price lookup
// Ports:
//   code   in  CODE_W   entered item code
//   price  out MONEY_W  price in cents, 0 marks an invalid code
module vend_price_rom
  import vend_pkg::*;
(
  input  logic [CODE_W-1:0]  code,
  output logic [MONEY_W-1:0] price
);

  always_comb begin
    price = '0;
    if (code != INVALID_CODE) begin
      price = PRICE_BASE + PRICE_STEP * MONEY_W'(code);
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// rtl/vend_sequencer.sv - one-purchase transaction sequencer with money/refund registers
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   tick       in   1 kHz single-cycle enable
//   switch     in   mode: 00 cancel, 01 code entry, 10 hold, 11 pay/confirm
//   in_pulse   in   debounced single-cycle key pulses
//   state      out  current state encoding
//   code       out  entered item code (two base-4 digits)
//   money      out  accumulated cents, saturating
//   refund     out  cents to return
//   indicator  out  code accepted (PAY, VEND)
//   LED        out  dispense (VEND)
//   err        out  one-cycle pulse on invalid code or abort
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int unsigned TIMEOUT_TICKS = 30000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic [1:0]         switch,
  input  logic [3:0]         in_pulse,
  output logic [2:0]         state,
  output logic [CODE_W-1:0]  code,
  output logic [MONEY_W-1:0] money,
  output logic [MONEY_W-1:0] refund,
  output logic               indicator,
  output logic               LED,
  output logic               err
);

  localparam int TMR_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(TIMEOUT_TICKS);

  state_t             state_q, state_n;
  logic [CODE_W-1:0]  code_q, code_n;
  logic               digit_q, digit_n;
  logic [MONEY_W-1:0] money_q, money_n;
  logic [MONEY_W-1:0] refund_q, refund_n;
  logic [TMR_W-1:0]   tmr_q, tmr_n;
  logic               indicator_q, led_q, err_q, err_n;

  logic               key_event;
  logic [1:0]         key_idx;
  logic [MONEY_W-1:0] price;
  logic [MONEY_W:0]   coin_sum;
  logic [MONEY_W-1:0] money_add;

  vend_price_rom u_price_rom (
    .code  (code_q),
    .price (price)
  );

  // Only a cycle with exactly one key bit counts; chords are dropped.
  always_comb begin
    key_event = 1'b1;
    key_idx   = 2'd0;
    case (in_pulse)
      4'b0001: key_idx = 2'd0;
      4'b0010: key_idx = 2'd1;
      4'b0100: key_idx = 2'd2;
      4'b1000: key_idx = 2'd3;
      default: key_event = 1'b0;
    endcase
  end

  // One extra bit catches overflow so money pins at full scale.
  assign coin_sum  = {1'b0, money_q} + {1'b0, coin_value(key_idx)};
  assign money_add = coin_sum[MONEY_W] ? MONEY_MAX : coin_sum[MONEY_W-1:0];

  always_comb begin
    state_n  = state_q;
    code_n   = code_q;
    digit_n  = digit_q;
    money_n  = money_q;
    refund_n = refund_q;
    tmr_n    = tmr_q;
    err_n    = 1'b0;

    // The timeout window is armed fresh every time PAY is entered.
    if (state_q != ST_PAY) begin
      tmr_n = TMR_RELOAD;
    end

    case (state_q)
      ST_IDLE: begin
        if (switch == SW_CODE) begin
          state_n  = ST_CODE;
          code_n   = '0;
          digit_n  = 1'b0;
          money_n  = '0;
          refund_n = '0;
        end
      end
      ST_CODE: begin
        if (switch == SW_CANCEL) begin
          state_n = ST_IDLE;
        end else if (key_event) begin
          code_n  = {code_q[1:0], key_idx};
          digit_n = 1'b1;
          if (digit_q) begin
            state_n = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (price != '0) begin
          state_n = ST_PAY;
        end else begin
          state_n = ST_IDLE;
          err_n   = 1'b1;
        end
      end
      ST_PAY: begin
        // Switch actions take priority over a coin in the same cycle;
        // a coin takes priority over a tick.
        if (switch == SW_CANCEL) begin
          state_n  = ST_ABORT;
          refund_n = money_q;
          err_n    = 1'b1;
        end else if (switch == SW_PAY && money_q >= price) begin
          state_n  = ST_VEND;
          refund_n = money_q - price;
        end else if (key_event) begin
          money_n = money_add;
          tmr_n   = TMR_RELOAD;
        end else if (tick) begin
          tmr_n = tmr_q - TMR_W'(1);
          if (tmr_q <= TMR_W'(1)) begin
            state_n  = ST_ABORT;
            refund_n = money_q;
            err_n    = 1'b1;
          end
        end
      end
      ST_VEND, ST_ABORT: begin
        if (switch == SW_CANCEL) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      code_q      <= '0;
      digit_q     <= 1'b0;
      money_q     <= '0;
      refund_q    <= '0;
      tmr_q       <= TMR_RELOAD;
      indicator_q <= 1'b0;
      led_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_n;
      code_q      <= code_n;
      digit_q     <= digit_n;
      money_q     <= money_n;
      refund_q    <= refund_n;
      tmr_q       <= tmr_n;
      indicator_q <= (state_n == ST_PAY) || (state_n == ST_VEND);
      led_q       <= (state_n == ST_VEND);
      err_q       <= err_n;
    end
  end

  assign state     = state_q;
  assign code      = code_q;
  assign money     = money_q;
  assign refund    = refund_q;
  assign indicator = indicator_q;
  assign LED       = led_q;
  assign err       = err_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// tb/tb_vend_sequencer.sv - self-checking bench for vend_sequencer
module tb_vend_sequencer;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic [1:0]  switch = 2'b00;
  logic [3:0]  in_pulse = 4'b0;
  logic [2:0]  state;
  logic [3:0]  code;
  logic [12:0] money, refund;
  logic        indicator, LED, err;

  int total = 0;
  int bad = 0;

  int m_state, m_code, m_digits, m_money, m_refund, m_timer;
  bit m_ind, m_led, m_err;
  int coin_tab[4] = '{5, 10, 25, 100};

  vend_sequencer #(.TIMEOUT_TICKS(T)) dut (
    .clk(clk), .reset(reset), .tick(tick), .switch(switch), .in_pulse(in_pulse),
    .state(state), .code(code), .money(money), .refund(refund),
    .indicator(indicator), .LED(LED), .err(err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0; m_code = 0; m_digits = 0; m_money = 0; m_refund = 0;
    m_timer = T; m_ind = 0; m_led = 0; m_err = 0;
  endtask

  // Transaction-level rules: price = 50 + 25*code (15 invalid), coins from a table.
  task automatic model_step(input logic [1:0] sw, input logic [3:0] p, input logic tk);
    int ns, idx, price;
    bit key, e;
    key = ($countones(p) == 1);
    idx = 0;
    for (int i = 0; i < 4; i++) if (p[i]) idx = i;
    price = (m_code == 15) ? 0 : 50 + 25 * m_code;
    ns = m_state;
    e = 0;
    if (m_state != 3) m_timer = T;
    case (m_state)
      0: if (sw == 2'b01) begin ns = 1; m_code = 0; m_digits = 0; m_money = 0; m_refund = 0; end
      1: begin
        if (sw == 2'b00) ns = 0;
        else if (key) begin
          m_code = (m_code * 4 + idx) % 16;
          m_digits++;
          if (m_digits == 2) ns = 2;
        end
      end
      2: if (price != 0) ns = 3; else begin ns = 0; e = 1; end
      3: begin
        if (sw == 2'b00) begin ns = 5; m_refund = m_money; e = 1; end
        else if (sw == 2'b11 && m_money >= price) begin ns = 4; m_refund = m_money - price; end
        else if (key) begin
          m_money = (m_money + coin_tab[idx] > 8191) ? 8191 : m_money + coin_tab[idx];
          m_timer = T;
        end else if (tk) begin
          m_timer--;
          if (m_timer == 0) begin ns = 5; m_refund = m_money; e = 1; end
        end
      end
      4, 5: if (sw == 2'b00) ns = 0;
      default: ns = 0;
    endcase
    m_state = ns;
    m_ind = (ns == 3) || (ns == 4);
    m_led = (ns == 4);
    m_err = e;
  endtask

  task automatic drive(input logic [1:0] sw, input logic [3:0] p, input logic tk);
    switch = sw; in_pulse = p; tick = tk;
    @(posedge clk);
    model_step(sw, p, tk);
    #1;
    switch = sw; in_pulse = 4'b0; tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if (code !== 4'd0) begin bad++; $display("FAIL reset_code got=%0d want=0", code); end
    total++; if (money !== 13'd0) begin bad++; $display("FAIL reset_money got=%0d want=0", money); end
    total++; if (refund !== 13'd0) begin bad++; $display("FAIL reset_refund got=%0d want=0", refund); end
    total++; if ({indicator, LED, err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {indicator, LED, err}); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_valid_purchase();
    drive(2'b01, 4'b0000, 0);
    total++; if (state !== 3'd1) begin bad++; $display("FAIL vp_code_state got=%0d want=1", state); end
    drive(2'b01, 4'b0001, 0);
    drive(2'b01, 4'b0100, 0);
    total++; if (state !== 3'd2 || code !== 4'd2) begin bad++; $display("FAIL vp_check got state=%0d code=%0d want state=2 code=2", state, code); end
    drive(2'b01, 4'b0000, 0);
    total++; if (state !== 3'd3 || indicator !== 1'b1) begin bad++; $display("FAIL vp_pay got state=%0d ind=%b want state=3 ind=1", state, indicator); end
    drive(2'b01, 4'b1000, 0);
    total++; if (money !== 13'd100) begin bad++; $display("FAIL vp_coin100 got=%0d want=100", money); end
    drive(2'b01, 4'b0100, 0);
    drive(2'b11, 4'b0000, 0);
    total++; if (state !== 3'd4 || LED !== 1'b1 || money !== 13'd125 || refund !== 13'd25)
      begin bad++; $display("FAIL vp_vend got state=%0d led=%b money=%0d refund=%0d want 4 1 125 25", state, LED, money, refund); end
    drive(2'b00, 4'b0000, 0);
    total++; if (state !== 3'd0 || LED !== 1'b0) begin bad++; $display("FAIL vp_idle got state=%0d led=%b want 0 0", state, LED); end
  endtask

  task automatic test_invalid_code();
    drive(2'b01, 4'b0000, 0);
    drive(2'b10, 4'b1000, 0);
    drive(2'b10, 4'b1000, 0);
    total++; if (state !== 3'd2 || code !== 4'd15) begin bad++; $display("FAIL inv_check got state=%0d code=%0d want 2 15", state, code); end
    drive(2'b10, 4'b0000, 0);
    total++; if (state !== 3'd0 || err !== 1'b1 || indicator !== 1'b0)
      begin bad++; $display("FAIL inv_err got state=%0d err=%b ind=%b want 0 1 0", state, err, indicator); end
    drive(2'b10, 4'b0000, 0);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL inv_err_pulse got=%b want=0", err); end
  endtask

  task automatic test_insufficient();
    drive(2'b01, 4'b0000, 0);
    drive(2'b10, 4'b0010, 0);
    drive(2'b10, 4'b0001, 0);
    drive(2'b10, 4'b0000, 0);
    drive(2'b10, 4'b1000, 0);
    drive(2'b10, 4'b0010, 0);
    drive(2'b11, 4'b0000, 0);
    total++; if (state !== 3'd3 || money !== 13'd110) begin bad++; $display("FAIL ins_stay got state=%0d money=%0d want 3 110", state, money); end
    drive(2'b11, 4'b0100, 0);
    drive(2'b11, 4'b0100, 0);
    total++; if (state !== 3'd3 || money !== 13'd160) begin bad++; $display("FAIL ins_coins got state=%0d money=%0d want 3 160", state, money); end
    drive(2'b11, 4'b0000, 0);
    total++; if (state !== 3'd4 || refund !== 13'd10) begin bad++; $display("FAIL ins_vend got state=%0d refund=%0d want 4 10", state, refund); end
    drive(2'b00, 4'b0000, 0);
  endtask

  task automatic test_cancel();
    drive(2'b01, 4'b0000, 0);
    drive(2'b10, 4'b0001, 0);
    drive(2'b10, 4'b0001, 0);
    drive(2'b10, 4'b0000, 0);
    drive(2'b10, 4'b0100, 0);
    drive(2'b10, 4'b0010, 0);
    drive(2'b00, 4'b0100, 0);
    total++; if (state !== 3'd5 || refund !== 13'd35 || money !== 13'd35 || err !== 1'b1 || indicator !== 1'b0)
      begin bad++; $display("FAIL cancel_abort got state=%0d refund=%0d money=%0d err=%b ind=%b want 5 35 35 1 0", state, refund, money, err, indicator); end
    drive(2'b00, 4'b0000, 0);
    total++; if (state !== 3'd0 || err !== 1'b0) begin bad++; $display("FAIL cancel_idle got state=%0d err=%b want 0 0", state, err); end
  endtask

  task automatic enter_pay_code1();
    drive(2'b01, 4'b0000, 0);
    drive(2'b10, 4'b0001, 0);
    drive(2'b10, 4'b0010, 0);
    drive(2'b10, 4'b0000, 0);
  endtask

  task automatic test_timeout();
    enter_pay_code1();
    for (int i = 0; i < T - 1; i++) begin drive(2'b10, 4'b0000, 1); drive(2'b10, 4'b0000, 0); end
    total++; if (state !== 3'd3) begin bad++; $display("FAIL to_before got state=%0d want=3", state); end
    drive(2'b10, 4'b0000, 1);
    total++; if (state !== 3'd5 || err !== 1'b1 || refund !== 13'd0)
      begin bad++; $display("FAIL to_abort got state=%0d err=%b refund=%0d want 5 1 0", state, err, refund); end
    drive(2'b00, 4'b0000, 0);
    enter_pay_code1();
    for (int i = 0; i < T - 1; i++) drive(2'b10, 4'b0000, 1);
    drive(2'b10, 4'b0001, 1);
    total++; if (state !== 3'd3 || money !== 13'd5) begin bad++; $display("FAIL to_coin_wins got state=%0d money=%0d want 3 5", state, money); end
    for (int i = 0; i < T - 1; i++) drive(2'b10, 4'b0000, 1);
    total++; if (state !== 3'd3) begin bad++; $display("FAIL to_reloaded got state=%0d want=3", state); end
    drive(2'b10, 4'b0000, 1);
    total++; if (state !== 3'd5 || refund !== 13'd5) begin bad++; $display("FAIL to_abort2 got state=%0d refund=%0d want 5 5", state, refund); end
    drive(2'b00, 4'b0000, 0);
  endtask

  task automatic test_edges();
    drive(2'b01, 4'b0000, 0);
    drive(2'b10, 4'b0011, 0);
    total++; if (state !== 3'd1 || code !== 4'd0) begin bad++; $display("FAIL edge_multi_code got state=%0d code=%0d want 1 0", state, code); end
    drive(2'b10, 4'b1000, 0);
    drive(2'b10, 4'b1111, 0);
    total++; if (state !== 3'd1 || code !== 4'd3) begin bad++; $display("FAIL edge_multi_code2 got state=%0d code=%0d want 1 3", state, code); end
    drive(2'b10, 4'b0001, 0);
    drive(2'b10, 4'b0000, 0);
    total++; if (state !== 3'd3 || code !== 4'd12) begin bad++; $display("FAIL edge_pay got state=%0d code=%0d want 3 12", state, code); end
    drive(2'b10, 4'b0110, 0);
    total++; if (money !== 13'd0) begin bad++; $display("FAIL edge_multi_coin got=%0d want=0", money); end
    for (int i = 0; i < 90; i++) drive(2'b10, 4'b1000, 0);
    total++; if (money !== 13'd8191) begin bad++; $display("FAIL edge_saturate got=%0d want=8191", money); end
    drive(2'b11, 4'b0000, 0);
    total++; if (state !== 3'd4 || refund !== 13'd7841) begin bad++; $display("FAIL edge_sat_vend got state=%0d refund=%0d want 4 7841", state, refund); end
    #3 reset = 1'b1;
    #1;
    total++; if ({state, code, money, refund, indicator, LED, err} !== 36'd0)
      begin bad++; $display("FAIL edge_async_reset got state=%0d code=%0d money=%0d refund=%0d ind=%b led=%b err=%b want all 0", state, code, money, refund, indicator, LED, err); end
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    logic [35:0] act_v, exp_v;
    logic [1:0] sw;
    logic [3:0] p;
    int r;
    for (int n = 0; n < 4000 && bad < 20; n++) begin
      r = $urandom_range(0, 9);
      sw = (r == 0) ? 2'b00 : (r < 4) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
      r = $urandom_range(0, 9);
      p = (r < 6) ? 4'b0000 : (r < 9) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      drive(sw, p, ($urandom_range(0, 3) == 0));
      act_v = {state, code, money, refund, indicator, LED, err};
      exp_v = {3'(m_state), 4'(m_code), 13'(m_money), 13'(m_refund), m_ind, m_led, m_err};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL random cycle=%0d got state=%0d code=%0d money=%0d refund=%0d ind=%b led=%b err=%b want %0d %0d %0d %0d %b %b %b",
                 n, state, code, money, refund, indicator, LED, err,
                 m_state, m_code, m_money, m_refund, m_ind, m_led, m_err);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_valid_purchase();
    test_invalid_code();
    test_insufficient();
    test_cancel();
    test_timeout();
    test_edges();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
